// File: rtl/pixel_adjust_filter_if.sv
// Valid/ready pixel stream carrying CHANNELS x DATA_WIDTH data plus a start-of-frame flag.
interface pixel_adjust_filter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNELS   = 1
);
    logic [CHANNELS*DATA_WIDTH-1:0] data;
    logic                           valid;
    logic                           sof;
    logic                           ready;

    modport master (output data, output valid, output sof, input ready);
    modport slave  (input data, input valid, input sof, output ready);
endinterface

// File: rtl/pixel_adjust_filter.sv
// Two-stage per-pixel point filter (bypass/brighten/darken/invert/threshold/contrast) with
// saturating arithmetic and configuration latched only on start-of-frame beats.
module pixel_adjust_filter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNELS   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            cfg_mode,
    input  logic [DATA_WIDTH-1:0] cfg_amount,
    pixel_adjust_filter_if.slave  s,
    pixel_adjust_filter_if.master m,
    output logic [15:0]           frame_count
);
    localparam int unsigned PW = CHANNELS * DATA_WIDTH;
    localparam int unsigned WW = 2 * DATA_WIDTH + 2;
    localparam logic signed [WW-1:0] MAX_W = WW'((1 << DATA_WIDTH) - 1);
    localparam logic signed [WW-1:0] MID_W = WW'(1 << (DATA_WIDTH - 1));

    typedef enum logic [2:0] {
        MODE_BYPASS    = 3'd0,
        MODE_BRIGHTEN  = 3'd1,
        MODE_DARKEN    = 3'd2,
        MODE_INVERT    = 3'd3,
        MODE_THRESHOLD = 3'd4,
        MODE_CONTRAST  = 3'd5
    } mode_e;

    mode_e                  mode_q;
    mode_e                  mode_in;
    mode_e                  beat_mode;
    logic [DATA_WIDTH-1:0]  amount_q;
    logic [DATA_WIDTH-1:0]  beat_amount;
    logic signed [WW-1:0]   amt_w;
    logic signed [WW-1:0]   x_w     [CHANNELS];
    logic signed [WW-1:0]   op_wide [CHANNELS];
    logic signed [WW-1:0]   s1_wide [CHANNELS];
    logic                   s1_valid;
    logic                   s1_sof;
    logic                   s1_adv;
    logic                   s_accept;
    logic                   sof_accept;
    logic [PW-1:0]          clamped;

    // Stage 1 may load whenever stage 2 is empty or draining; no path from s.valid.
    assign s1_adv     = !m.valid || m.ready;
    assign s.ready    = !s1_valid || s1_adv;
    assign s_accept   = s.valid && s.ready;
    assign sof_accept = s_accept && s.sof;
    assign mode_in    = (cfg_mode > 3'd5) ? MODE_BYPASS : mode_e'(cfg_mode);

    // The sof beat itself already uses the freshly presented configuration.
    always_comb begin
        beat_mode   = mode_q;
        beat_amount = amount_q;
        if (sof_accept) begin
            beat_mode   = mode_in;
            beat_amount = cfg_amount;
        end
    end

    assign amt_w = WW'(beat_amount);

    // Unclamped point operation, evaluated in a signed domain wide enough for contrast.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            x_w[c]     = WW'(s.data[c*DATA_WIDTH +: DATA_WIDTH]);
            op_wide[c] = x_w[c];
            case (beat_mode)
                MODE_BRIGHTEN:  op_wide[c] = x_w[c] + amt_w;
                MODE_DARKEN:    op_wide[c] = x_w[c] - amt_w;
                MODE_INVERT:    op_wide[c] = MAX_W - x_w[c];
                MODE_THRESHOLD: op_wide[c] = (x_w[c] >= amt_w) ? MAX_W : '0;
                MODE_CONTRAST:  op_wide[c] = (((x_w[c] - MID_W) * amt_w) >>> 4) + MID_W;
                default:        op_wide[c] = x_w[c];
            endcase
        end
    end

    always_comb begin
        clamped = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (s1_wide[c][WW-1])
                clamped[c*DATA_WIDTH +: DATA_WIDTH] = '0;
            else if (s1_wide[c] > MAX_W)
                clamped[c*DATA_WIDTH +: DATA_WIDTH] = '1;
            else
                clamped[c*DATA_WIDTH +: DATA_WIDTH] = s1_wide[c][DATA_WIDTH-1:0];
        end
    end

    // Stage 1 and the frame-boundary configuration shadow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            mode_q   <= MODE_BYPASS;
            amount_q <= '0;
            for (int c = 0; c < CHANNELS; c++) s1_wide[c] <= '0;
        end else begin
            if (s.ready) begin
                s1_valid <= s.valid;
                s1_sof   <= s.valid && s.sof;
                for (int c = 0; c < CHANNELS; c++) s1_wide[c] <= op_wide[c];
            end
            if (sof_accept) begin
                mode_q   <= mode_in;
                amount_q <= cfg_amount;
            end
        end
    end

    // Stage 2 holds the clamped beat until downstream takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m.valid <= 1'b0;
            m.sof   <= 1'b0;
            m.data  <= '0;
        end else if (s1_adv) begin
            m.valid <= s1_valid;
            m.sof   <= s1_sof;
            m.data  <= clamped;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_count <= '0;
        else if (m.valid && m.ready && m.sof)
            frame_count <= frame_count + 16'd1;
    end
endmodule

// File: tb/tb_pixel_adjust_filter.sv
// Bench for pixel_adjust_filter: directed saturation vectors plus a randomized stream
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_pixel_adjust_filter;
    localparam int unsigned DW = 8;
    localparam int unsigned CH = 3;
    localparam int unsigned PW = DW * CH;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  cfg_mode;
    logic [7:0]  cfg_amount;
    logic [15:0] frame_count;

    pixel_adjust_filter_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) s_if ();
    pixel_adjust_filter_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) m_if ();

    pixel_adjust_filter #(.DATA_WIDTH(DW), .CHANNELS(CH)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_mode    (cfg_mode),
        .cfg_amount  (cfg_amount),
        .s           (s_if),
        .m           (m_if),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] data;
        logic          sof;
        logic [2:0]    mode;
        logic [7:0]    amt;
        logic          has_exp;
        logic [PW-1:0] exp;
    } beat_t;

    typedef struct {
        logic [PW-1:0] data;
        logic          sof;
        int            cyc;
    } exp_t;

    beat_t         in_q[$];
    exp_t          exp_q[$];
    int            tests = 0;
    int            failed = 0;
    int            ncyc = 0;
    int            fc = 0;
    int            vprob, rprob;
    int            sh_mode, sh_amt;
    bit            chk_lat, chk_sready;
    bit            stall_pend;
    logic [PW-1:0] stall_data;
    logic          stall_sof;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference for one channel: plain integer arithmetic, floor-divided gain, then clamp.
    function automatic int ref_ch(input int mode, input int amt, input int x);
        int r, v;
        case (mode)
            1: r = x + amt;
            2: r = x - amt;
            3: r = 255 - x;
            4: r = (x >= amt) ? 255 : 0;
            5: begin
                v = (x - 128) * amt;
                r = ((v >= 0) ? v / 16 : -((15 - v) / 16)) + 128;
            end
            default: r = x;
        endcase
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    function automatic logic [PW-1:0] ref_px(input int mode, input int amt, input logic [PW-1:0] px);
        logic [PW-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++)
            r[c*DW +: DW] = 8'(ref_ch(mode, amt, int'(px[c*DW +: DW])));
        return r;
    endfunction

    function automatic logic [PW-1:0] rep(input int v);
        logic [7:0] b;
        b = 8'(v);
        return {b, b, b};
    endfunction

    task automatic send(input logic [PW-1:0] d, input bit sof, input int mode, input int amt,
                        input bit has_exp, input logic [PW-1:0] exp);
        beat_t b;
        b.data = d; b.sof = sof; b.mode = 3'(mode); b.amt = 8'(amt);
        b.has_exp = has_exp; b.exp = exp;
        in_q.push_back(b);
    endtask

    task automatic dsend(input int x, input bit sof, input int mode, input int amt, input int ex);
        send(rep(x), sof, mode, amt, 1'b1, rep(ex));
    endtask

    // Present the head beat (or idle noise); cfg is only meaningful on sof beats.
    task automatic drive();
        if (in_q.size() > 0 && int'($urandom_range(99)) < vprob) begin
            s_if.valid = 1'b1;
            s_if.data  = in_q[0].data;
            s_if.sof   = in_q[0].sof;
            if (in_q[0].sof) begin
                cfg_mode   = in_q[0].mode;
                cfg_amount = in_q[0].amt;
            end else begin
                cfg_mode   = 3'($urandom);
                cfg_amount = 8'($urandom);
            end
        end else begin
            s_if.valid = 1'b0;
            s_if.data  = PW'($urandom);
            s_if.sof   = 1'($urandom);
            cfg_mode   = 3'($urandom);
            cfg_amount = 8'($urandom);
        end
        m_if.ready = (int'($urandom_range(99)) < rprob);
    endtask

    // Observe handshakes at the falling edge, then drive the next cycle after the rising edge.
    task automatic tick();
        beat_t b;
        exp_t  e;
        @(negedge clk);
        ncyc++;
        check("frame_count", 32'(frame_count), 32'(fc));
        if (stall_pend) begin
            check("stall_valid", 32'(m_if.valid), 32'(1));
            check("stall_data", 32'(m_if.data), 32'(stall_data));
            check("stall_sof", 32'(m_if.sof), 32'(stall_sof));
        end
        if (chk_sready) check("s_ready_stream", 32'(s_if.ready), 32'(1));
        if (s_if.valid && s_if.ready) begin
            b = in_q.pop_front();
            if (s_if.sof) begin
                sh_mode = int'(cfg_mode);
                sh_amt  = int'(cfg_amount);
            end
            e.data = b.has_exp ? b.exp : ref_px(sh_mode, sh_amt, s_if.data);
            e.sof  = s_if.sof;
            e.cyc  = ncyc;
            exp_q.push_back(e);
        end
        if (m_if.valid && m_if.ready) begin
            tests++;
            assert (exp_q.size() > 0) else begin
                failed++;
                $error("FAIL extra_beat: observed %0h expected no beat", m_if.data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("m_data", 32'(m_if.data), 32'(e.data));
                check("m_sof", 32'(m_if.sof), 32'(e.sof));
                if (chk_lat) check("latency", 32'(ncyc - e.cyc), 32'(2));
                if (e.sof) fc = (fc + 1) & 16'hFFFF;
            end
        end
        stall_pend = m_if.valid && !m_if.ready;
        stall_data = m_if.data;
        stall_sof  = m_if.sof;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int limit);
        int n;
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < limit) begin
            tick();
            n++;
        end
        tests++;
        assert (in_q.size() == 0 && exp_q.size() == 0) else begin
            failed++;
            $error("FAIL drain: observed %0d beats pending expected 0", in_q.size() + exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        s_if.valid = 1'b0; s_if.data = '0; s_if.sof = 1'b0;
        m_if.ready = 1'b0; cfg_mode = '0; cfg_amount = '0;
        vprob = 100; rprob = 100; chk_lat = 0; chk_sready = 0;
        sh_mode = 0; sh_amt = 0; stall_pend = 0; stall_data = '0; stall_sof = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_if.valid), 32'(0));
        check("rst_m_sof", 32'(m_if.sof), 32'(0));
        check("rst_m_data", 32'(m_if.data), 32'(0));
        check("rst_frame_count", 32'(frame_count), 32'(0));
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check("s_ready_after_reset", 32'(s_if.ready), 32'(1));

        // Bypass ramp at full throughput: exact 2-clock latency, s_ready never drops.
        for (int x = 0; x < 256; x++) dsend(x, x == 0, 0, 0, x);
        chk_lat = 1; chk_sready = 1;
        drive();
        run(2000);
        tick();
        check("frame_count_after_ramp", 32'(frame_count), 32'(1));
        chk_lat = 0; chk_sready = 0;

        // Saturation boundaries and every operation, back to back across sof changes.
        dsend(0, 1, 1, 32, 32);   dsend(100, 0, 0, 0, 132); dsend(223, 0, 0, 0, 255);
        dsend(224, 0, 0, 0, 255); dsend(255, 0, 0, 0, 255); dsend(250, 1, 1, 10, 255);
        dsend(0, 1, 2, 32, 0);    dsend(100, 0, 0, 0, 68);  dsend(223, 0, 0, 0, 191);
        dsend(224, 0, 0, 0, 192); dsend(255, 0, 0, 0, 223); dsend(5, 1, 2, 10, 0);
        dsend(0, 1, 4, 0, 255);   dsend(77, 0, 0, 0, 255);
        dsend(127, 1, 4, 128, 0); dsend(128, 0, 0, 0, 255);
        dsend(0, 1, 5, 32, 0);    dsend(64, 0, 0, 0, 0);    dsend(128, 0, 0, 0, 128);
        dsend(200, 0, 0, 0, 255); dsend(255, 0, 0, 0, 255); dsend(0, 1, 5, 8, 64);
        dsend(33, 1, 6, 99, 33);
        // Brighten frame whose non-sof cfg noise must be ignored, then invert from the sof.
        dsend(10, 1, 1, 50, 60);  dsend(10, 0, 3, 0, 60);   dsend(200, 0, 3, 0, 250);
        dsend(10, 1, 3, 0, 245);  dsend(20, 0, 0, 0, 235);
        send({8'd3, 8'd2, 8'd1}, 1'b0, 0, 0, 1'b1, {8'd252, 8'd253, 8'd254});
        drive();
        run(500);
        tick();

        // Randomized traffic with 50% backpressure against the reference model.
        vprob = 75; rprob = 50;
        for (int i = 0; i < 1000; i++)
            send(PW'($urandom), (i == 0) || ($urandom_range(39) == 0),
                 int'($urandom_range(7)), int'($urandom_range(255)), 1'b0, '0);
        drive();
        run(20000);
        tick();

        // Fill both stages under backpressure, then reset with them in flight.
        vprob = 100; rprob = 0;
        send(rep(1), 1'b1, 1, 9, 1'b0, '0);
        send(rep(2), 1'b0, 0, 0, 1'b0, '0);
        drive();
        repeat (4) tick();
        check("s_ready_full", 32'(s_if.ready), 32'(0));
        check("m_valid_full", 32'(m_if.valid), 32'(1));
        reset = 1'b1;
        #1;
        check("m_valid_in_reset", 32'(m_if.valid), 32'(0));
        check("frame_count_in_reset", 32'(frame_count), 32'(0));
        in_q.delete(); exp_q.delete();
        stall_pend = 0; fc = 0; sh_mode = 0; sh_amt = 0;
        s_if.valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check("s_ready_after_reset2", 32'(s_if.ready), 32'(1));
        rprob = 100;
        dsend(7, 0, 1, 50, 7); dsend(200, 0, 1, 50, 200); dsend(10, 1, 3, 0, 245);
        drive();
        run(200);
        tick();
        check("frame_count_end", 32'(frame_count), 32'(1));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
